// File: rtl/buf_audio_out.sv
// Stereo-pair FIFO feeding a free-running I2S transmitter (MSB first, no one-bit delay).
// Latency: a pushed pair is visible in fill_level next cycle; it is sent in the next frame load.
// Backpressure: write_ready drops when the FIFO is full; pushes while full are discarded.

module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    // Generic show-ahead FIFO, power-of-two depth.
    // Latency: one cycle from push to rd_vld; read data is combinational from the head entry.
    // Backpressure: wr_rdy low while full; rd_vld low while empty.
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push;
    logic             pop;

    assign wr_rdy = (cnt != FULL_CNT);
    assign rd_vld = (cnt != '0);
    assign push   = wr_vld & wr_rdy;
    assign pop    = rd_vld & rd_rdy;
    assign rd_dat = mem[rd_ptr];
    assign count  = cnt;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module buf_audio_out #(
    parameter int AUDIO_WIDTH  = 24,
    parameter int I2S_WIDTH    = 24,
    parameter int BUFFER_DEPTH = 8,
    parameter int BCLK_HALF    = 18
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic                            enable,
    input  logic                            write_enable,
    input  logic [AUDIO_WIDTH-1:0]          audio_left_in,
    input  logic [AUDIO_WIDTH-1:0]          audio_right_in,
    output logic                            write_ready,
    output logic                            buffer_empty,
    output logic                            buffer_full,
    output logic [$clog2(BUFFER_DEPTH):0]   fill_level,
    output logic                            underrun,
    output logic                            i2s_bclk,
    output logic                            i2s_lrclk,
    output logic                            i2s_data
);
    // I2S transmitter: pops one stereo pair per frame, sends zeros and flags underrun when empty.
    // Latency: frame load on the enable cycle, first bit valid immediately after; bclk rises BCLK_HALF later.
    // Backpressure: write_ready = ~buffer_full from the registered count; full pushes are dropped.
    localparam int FRAME_BITS = 2 * I2S_WIDTH;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = $clog2(BCLK_HALF);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    typedef struct packed {
        logic [AUDIO_WIDTH-1:0] left;
        logic [AUDIO_WIDTH-1:0] right;
    } pair_t;

    logic [1:0]            rst_pipe;
    logic                  rst_n;
    logic [0:0]            state;
    logic [DIV_W-1:0]      div;
    logic [BIT_W-1:0]      bit_idx;
    logic [FRAME_BITS-1:0] sr;
    logic [FRAME_BITS-1:0] load_frame;
    logic [I2S_WIDTH-1:0]  left_slot;
    logic [I2S_WIDTH-1:0]  right_slot;
    pair_t                 wr_pair;
    pair_t                 rd_pair;
    logic                  fifo_vld;
    logic                  frame_load;
    logic                  div_last;
    logic                  bclk_fall;
    logic                  last_bit;

    // Asserts with sys_rst, releases two sys_clk edges later.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    assign wr_pair = {audio_left_in, audio_right_in};

    fifo #(
        .WIDTH ($bits(pair_t)),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk    (sys_clk),
        .rst_n  (rst_n),
        .wr_vld (write_enable),
        .wr_rdy (write_ready),
        .wr_dat (wr_pair),
        .rd_vld (fifo_vld),
        .rd_rdy (frame_load),
        .rd_dat (rd_pair),
        .count  (fill_level)
    );

    assign buffer_empty = ~fifo_vld;
    assign buffer_full  = ~write_ready;

    generate
        if (AUDIO_WIDTH == I2S_WIDTH) begin : g_eq
            assign left_slot  = rd_pair.left;
            assign right_slot = rd_pair.right;
        end else if (AUDIO_WIDTH > I2S_WIDTH) begin : g_trunc
            assign left_slot  = rd_pair.left[AUDIO_WIDTH-1 -: I2S_WIDTH];
            assign right_slot = rd_pair.right[AUDIO_WIDTH-1 -: I2S_WIDTH];
        end else begin : g_pad
            assign left_slot  = {rd_pair.left,  {(I2S_WIDTH-AUDIO_WIDTH){1'b0}}};
            assign right_slot = {rd_pair.right, {(I2S_WIDTH-AUDIO_WIDTH){1'b0}}};
        end
    endgenerate

    assign load_frame = fifo_vld ? {left_slot, right_slot} : '0;
    assign div_last   = (div == DIV_W'(BCLK_HALF - 1));
    assign bclk_fall  = (state == RUN) && div_last && i2s_bclk;
    assign last_bit   = (bit_idx == BIT_W'(FRAME_BITS - 1));
    assign frame_load = (state == IDLE) ? enable : (bclk_fall && last_bit && enable);
    assign i2s_data   = sr[FRAME_BITS-1];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div       <= '0;
            bit_idx   <= '0;
            sr        <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= frame_load & ~fifo_vld;
            case (state)
                IDLE: begin
                    div       <= '0;
                    bit_idx   <= '0;
                    i2s_bclk  <= 1'b0;
                    i2s_lrclk <= 1'b0;
                    sr        <= enable ? load_frame : '0;
                    if (enable) state <= RUN;
                end
                default: begin
                    if (div_last) begin
                        div      <= '0;
                        i2s_bclk <= ~i2s_bclk;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                    // Data and word select only move on the falling bclk edge.
                    if (bclk_fall) begin
                        if (last_bit) begin
                            bit_idx   <= '0;
                            i2s_lrclk <= 1'b0;
                            if (enable) begin
                                sr <= load_frame;
                            end else begin
                                sr    <= '0;
                                state <= IDLE;
                            end
                        end else begin
                            bit_idx   <= bit_idx + BIT_W'(1);
                            i2s_lrclk <= (bit_idx >= BIT_W'(I2S_WIDTH - 1));
                            sr        <= {sr[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_buf_audio_out.sv
// Bench for buf_audio_out: I2S receiver model feeds a scoreboard of expected slot words.
module tb_buf_audio_out;
    localparam int AW = 24;
    localparam int IW = 24;
    localparam int DEPTH = 4;
    localparam int BH = 2;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          enable = 1'b0;
    logic          write_enable = 1'b0;
    logic [AW-1:0] audio_left_in = '0;
    logic [AW-1:0] audio_right_in = '0;
    logic          write_ready;
    logic          buffer_empty;
    logic          buffer_full;
    logic [2:0]    fill_level;
    logic          underrun;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_data;

    always #5 sys_clk = ~sys_clk;

    buf_audio_out #(
        .AUDIO_WIDTH  (AW),
        .I2S_WIDTH    (IW),
        .BUFFER_DEPTH (DEPTH),
        .BCLK_HALF    (BH)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .enable         (enable),
        .write_enable   (write_enable),
        .audio_left_in  (audio_left_in),
        .audio_right_in (audio_right_in),
        .write_ready    (write_ready),
        .buffer_empty   (buffer_empty),
        .buffer_full    (buffer_full),
        .fill_level     (fill_level),
        .underrun       (underrun),
        .i2s_bclk       (i2s_bclk),
        .i2s_lrclk      (i2s_lrclk),
        .i2s_data       (i2s_data)
    );

    int checks = 0;
    int passed = 0;
    logic [IW:0] sb [$];

    int cyc = 0;
    int rx_cnt = 0;
    int rx_words = 0;
    int rx_prev = 0;
    int rx_per = 4;
    logic rx_lr = 1'b0;
    logic [IW-1:0] rx_sh = '0;
    bit lr_err = 1'b0;
    bit wide = 1'b0;
    bit u_prev = 1'b0;
    int u_cnt = 0;
    int ub;
    int wb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(posedge sys_clk) cyc++;

    // Receiver: samples on bclk rising, one word per 24 bits, word select latched at slot start.
    always @(posedge i2s_bclk or negedge sys_rst) begin
        if (!sys_rst) begin
            rx_cnt = 0;
        end else begin
            if (rx_cnt > 0) rx_per = cyc - rx_prev;
            rx_prev = cyc;
            if (rx_cnt == 0) rx_lr = i2s_lrclk;
            else if (i2s_lrclk !== rx_lr) lr_err = 1'b1;
            rx_sh = {rx_sh[IW-2:0], i2s_data};
            rx_cnt++;
            if (rx_cnt == IW) begin
                rx_cnt = 0;
                rx_words++;
                check("bclk_period", rx_per, 4);
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_word: got lr=%0d data=0x%06h, expected no word", rx_lr, rx_sh);
                end else begin
                    check("slot_word", {7'd0, rx_lr, rx_sh}, {7'd0, sb.pop_front()});
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        if (underrun && u_prev) wide = 1'b1;
        if (underrun && !u_prev) u_cnt++;
        u_prev = underrun;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic exp_frame(input logic [IW-1:0] l, input logic [IW-1:0] r);
        sb.push_back({1'b0, l});
        sb.push_back({1'b1, r});
    endtask

    task automatic push_pair(input logic [AW-1:0] l, input logic [AW-1:0] r);
        @(negedge sys_clk);
        write_enable   = 1'b1;
        audio_left_in  = l;
        audio_right_in = r;
        @(negedge sys_clk);
        write_enable   = 1'b0;
    endtask

    task automatic wait_words(input int target, input string name);
        int n = 0;
        while (rx_words < target && n < 2000) begin @(negedge sys_clk); n++; end
        check(name, 32'(rx_words >= target), 1);
    endtask

    task automatic wait_underruns(input int target, input string name);
        int n = 0;
        while (u_cnt < target && n < 2000) begin @(negedge sys_clk); n++; end
        check(name, 32'(u_cnt >= target), 1);
    endtask

    task automatic wait_fill0(input string name);
        int n = 0;
        while (fill_level != 0 && n < 1000) begin @(negedge sys_clk); n++; end
        check(name, 32'(fill_level), 0);
    endtask

    task automatic wait_rx(input logic lr, input int cnt, input string name);
        int n = 0;
        while (!(rx_cnt == cnt && rx_lr == lr) && n < 1000) begin @(negedge sys_clk); n++; end
        check(name, 32'(rx_cnt == cnt && rx_lr == lr), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_fill"},  32'(fill_level), 0);
        check({tag, "_empty"}, 32'(buffer_empty), 1);
        check({tag, "_full"},  32'(buffer_full), 0);
        check({tag, "_wrdy"},  32'(write_ready), 1);
        check({tag, "_under"}, 32'(underrun), 0);
        check({tag, "_bclk"},  32'(i2s_bclk), 0);
        check({tag, "_lrclk"}, 32'(i2s_lrclk), 0);
        check({tag, "_data"},  32'(i2s_data), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        // Reset state and release
        idle(3);
        check_reset_vals("rst");
        sys_rst = 1'b1;
        idle(4);
        check_reset_vals("post_rst");

        // One frame, enable dropped at left bit 5, second pair left untouched
        push_pair(24'h123456, 24'hABCDEF);
        check("b_fill1", 32'(fill_level), 1);
        push_pair(24'h654321, 24'h0F0F0F);
        check("b_fill2", 32'(fill_level), 2);
        exp_frame(24'h123456, 24'hABCDEF);
        ub = u_cnt; wb = rx_words;
        enable = 1'b1;
        wait_rx(1'b0, 5, "b_wait_left5");
        enable = 1'b0;
        wait_words(wb + 2, "b_words");
        idle(6);
        check("b_idle_bclk", 32'(i2s_bclk), 0);
        check("b_idle_lrclk", 32'(i2s_lrclk), 0);
        check("b_idle_data", 32'(i2s_data), 0);
        check("b_fill_kept", 32'(fill_level), 1);
        idle(40);
        check("b_stay_idle", 32'(i2s_bclk), 0);
        check("b_no_underrun", u_cnt - ub, 0);

        // Reset in the middle of the right slot
        push_pair(24'h111111, 24'h222222);
        push_pair(24'h333333, 24'h444444);
        check("r_fill3", 32'(fill_level), 3);
        sb.push_back({1'b0, 24'h654321});
        enable = 1'b1;
        wait_rx(1'b1, 10, "r_wait_right10");
        check("r_fill2", 32'(fill_level), 2);
        sys_rst = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        enable = 1'b0;
        idle(2);
        sys_rst = 1'b1;
        idle(4);
        ub = u_cnt; wb = rx_words;
        exp_frame(24'h0, 24'h0);
        enable = 1'b1;
        wait_underruns(ub + 1, "r_wait_underrun");
        enable = 1'b0;
        wait_words(wb + 2, "r_words");
        idle(6);
        check("r_underrun_cnt", u_cnt - ub, 1);

        // Fill to full, fifth push dropped
        ub = u_cnt; wb = rx_words;
        for (int i = 0; i < 5; i++) begin
            push_pair(24'h100000 + 24'(i), 24'h200000 + 24'(i));
            if (i < 4) exp_frame(24'h100000 + 24'(i), 24'h200000 + 24'(i));
            if (i == 3) begin
                check("c_full", 32'(buffer_full), 1);
                check("c_wrdy", 32'(write_ready), 0);
                check("c_fill4", 32'(fill_level), 4);
            end
        end
        check("c_drop_fill", 32'(fill_level), 4);
        exp_frame(24'h0, 24'h0);
        enable = 1'b1;
        wait_underruns(ub + 1, "c_wait_underrun");
        enable = 1'b0;
        wait_words(wb + 10, "c_words");
        idle(6);
        check("c_underrun_cnt", u_cnt - ub, 1);
        check("c_empty", 32'(buffer_empty), 1);

        // Start empty, push during frame 2, sent in frame 3
        ub = u_cnt; wb = rx_words;
        exp_frame(24'h0, 24'h0);
        exp_frame(24'h0, 24'h0);
        enable = 1'b1;
        wait_underruns(ub + 2, "d_wait_underrun2");
        idle(10);
        push_pair(24'h0A0B0C, 24'h0D0E0F);
        exp_frame(24'h0A0B0C, 24'h0D0E0F);
        check("d_fill1", 32'(fill_level), 1);
        wait_fill0("d_popped");
        enable = 1'b0;
        wait_words(wb + 6, "d_words");
        idle(6);
        check("d_underrun_cnt", u_cnt - ub, 2);

        // Push on the same cycle as an empty frame load is stored, not bypassed
        ub = u_cnt; wb = rx_words;
        exp_frame(24'h0, 24'h0);
        exp_frame(24'h5A5A5A, 24'hA5A5A5);
        @(negedge sys_clk);
        enable         = 1'b1;
        write_enable   = 1'b1;
        audio_left_in  = 24'h5A5A5A;
        audio_right_in = 24'hA5A5A5;
        @(negedge sys_clk);
        write_enable   = 1'b0;
        check("e_push_kept", 32'(fill_level), 1);
        wait_fill0("e_popped");
        enable = 1'b0;
        wait_words(wb + 4, "e_words");
        idle(6);
        check("e_underrun_cnt", u_cnt - ub, 1);

        check("sb_drained", sb.size(), 0);
        check("lrclk_stable_in_slot", 32'(lr_err), 0);
        check("underrun_one_cycle", 32'(wide), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/buf_audio_out.md
BUF_AUDIO_OUT -- requirements
Module: buf_audio_out

Interface
REQ-001 SHALL have parameter AUDIO_WIDTH, default 24: width of each parallel mono sample.
REQ-002 SHALL have parameter I2S_WIDTH, default 24: bits per I2S slot; two slots (L, R) per frame.
REQ-003 SHALL have parameter BUFFER_DEPTH, default 8, power of two >= 2: stereo-pair FIFO depth.
REQ-004 SHALL have parameter BCLK_HALF, default 18, >= 2: sys_clk cycles per i2s_bclk half-period.
REQ-005 SHALL have port sys_clk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port enable, input, 1: run request for the serial transmitter.
REQ-008 SHALL have port write_enable, input, 1: push request for one stereo pair.
REQ-009 SHALL have port audio_left_in, input, AUDIO_WIDTH: left sample to push.
REQ-010 SHALL have port audio_right_in, input, AUDIO_WIDTH: right sample to push.
REQ-011 SHALL have port write_ready, output, 1: FIFO can accept a push.
REQ-012 SHALL have port buffer_empty, output, 1: FIFO holds zero pairs.
REQ-013 SHALL have port buffer_full, output, 1: FIFO holds BUFFER_DEPTH pairs.
REQ-014 SHALL have port fill_level, output, $clog2(BUFFER_DEPTH)+1: pairs stored.
REQ-015 SHALL have port underrun, output, 1: one-cycle pulse on empty frame load.
REQ-016 SHALL have port i2s_bclk, output, 1: generated bit clock.
REQ-017 SHALL have port i2s_lrclk, output, 1: word select; 0 = left, 1 = right.
REQ-018 SHALL have port i2s_data, output, 1: serial data, MSB first.

Function
REQ-019 SHALL make write_ready = ~buffer_full, derived from registered state only.
REQ-020 SHALL accept a push on write_enable & write_ready; it SHALL silently drop a push while full, leaving stored data intact (no overwrite).
REQ-021 SHALL update fill_level, buffer_empty and buffer_full one cycle after any push/pop; a simultaneous push and pop SHALL leave fill_level unchanged.
REQ-022 SHALL implement states IDLE and RUN; IDLE -> RUN on enable=1; RUN -> IDLE only at a frame boundary with enable=0.
REQ-023 In IDLE, SHALL hold i2s_bclk=0, i2s_lrclk=0, i2s_data=0 and the divider cleared.
REQ-024 In RUN, SHALL toggle i2s_bclk every BCLK_HALF sys_clk cycles; frame = 2*I2S_WIDTH bclk periods.
REQ-025 SHALL change i2s_data and i2s_lrclk only coincident with bclk falling (or on IDLE->RUN entry); the receiver samples on bclk rising.
REQ-026 SHALL drive i2s_lrclk=0 for bit indices 0..I2S_WIDTH-1 and 1 for I2S_WIDTH..2*I2S_WIDTH-1, with the slot MSB in the first bit of each slot (no one-bit delay).
REQ-027 SHALL perform a frame load (pop one pair) on the IDLE->RUN entry cycle and on each falling edge that wraps the bit index to 0.
REQ-028 SHALL MSB-align samples into the slot: zero-pad LSBs if AUDIO_WIDTH < I2S_WIDTH, drop LSBs if greater.
REQ-029 If the FIFO is empty at frame load, SHALL transmit an all-zero frame and pulse underrun for exactly one cycle; a push in that same cycle SHALL be stored, not bypassed.
REQ-030 If enable falls mid-frame, SHALL complete the right slot, then enter IDLE without popping.

Reset
REQ-031 On sys_rst=0, SHALL immediately force IDLE, empty FIFO (fill_level=0, buffer_empty=1, buffer_full=0, write_ready=1), underrun=0, i2s_bclk=0, i2s_lrclk=0, i2s_data=0, regardless of frame position.
REQ-032 SHALL release reset synchronously to sys_clk and stay in IDLE until enable is sampled high.

Verification (BCLK_HALF=2, I2S_WIDTH=AUDIO_WIDTH=24, BUFFER_DEPTH=4)
REQ-033 Reset asserted, then released -> every output equals its REQ-031 value.
REQ-034 Push L=0x123456 R=0xABCDEF, raise enable -> bench I2S receiver captures 0x123456 with lrclk=0 and 0xABCDEF with lrclk=1; bclk period 4 sys_clk cycles.
REQ-035 Push 0x100000+i / 0x200000+i for i=0..4 while disabled -> full=1 and write_ready=0 after the 4th; the 5th is dropped; enable -> L sequence 0x100000..0x100003, then zero frame with underrun pulse.
REQ-036 Enable with empty FIFO -> zero frames, one underrun pulse per frame; push during frame 2 -> that pair sent in frame 3.
REQ-037 Deassert enable at left bit 5 -> right slot completes, then bclk=lrclk=data=0 and fill_level unchanged.
REQ-038 Assert reset at right bit 10 with 2 pairs buffered -> outputs zero same cycle, fill_level=0; re-enable -> zero frame plus underrun.
